reg_readout_unit: RTL

Sequential reader for the processor's 32x32-bit register file. The register file writes on the negative clock edge. This block reads the registers on the positive edge, one index at a time from a start index through the last register. Each word is presented on a valid/ready output stream to the debug/display path. It is the read-side counterpart of the register write path and never writes a register.

---
 rtl/reg_readout_unit.sv | 74 +++++++
 1 files changed

// File: rtl/reg_readout_unit.sv
// reg_readout_unit: sweeps the register file from startIdx up to the last register,
// presenting one captured word per valid/ready handshake.
module reg_readout_unit #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W = 32,
   parameter int IDX_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  startIdx,
   input  logic              abort,
   output logic [IDX_W-1:0]  rdIndex,
   input  logic [DATA_W-1:0] rdData,
   output logic [DATA_W-1:0] outData,
   output logic [IDX_W-1:0]  outIdx,
   output logic              outValid,
   input  logic              outReady,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;
   state_t state, state_d;
   logic [IDX_W-1:0] idx, idx_d, oidx_d;
   logic [DATA_W-1:0] data_d;
   logic last, accept, in_range;
   assign last = idx == IDX_W'(NUM_REGS - 1);
   assign accept = outValid && outReady;
   assign in_range = int'(startIdx) < NUM_REGS;
   assign rdIndex = idx;
   always_comb begin
      state_d = state;
      idx_d = idx;
      data_d = outData;
      oidx_d = outIdx;
      case (state)
         IDLE: if (start) begin
            state_d = in_range ? FETCH : FINISH;
            idx_d = in_range ? startIdx : idx;
         end
         FETCH: if (abort) state_d = IDLE;
         else begin
            state_d = PRESENT;
            data_d = rdData;
            oidx_d = idx;
         end
         // abort outranks a simultaneous accept; the held word is simply dropped
         PRESENT: if (abort) state_d = IDLE;
         else if (accept) begin
            state_d = last ? FINISH : FETCH;
            idx_d = last ? idx : idx + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         idx <= '0;
         outData <= '0;
         outIdx <= '0;
         outValid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_d;
         idx <= idx_d;
         outData <= data_d;
         outIdx <= oidx_d;
         outValid <= state_d == PRESENT;
         busy <= state_d == FETCH || state_d == PRESENT;
         done <= state_d == FINISH;
      end
endmodule
